// File: rtl/packet_fifo_pkg.sv
// Shared constants and unit/length types for the router packet FIFOs.
// Default geometry: 4 entries of up to 11 byte-wide units each.
package packet_fifo_pkg;

    localparam int PF_DEPTH     = 4;
    localparam int PF_WIDTH     = 11;
    localparam int PF_UWIDTH    = 8;
    localparam int PF_PTR_SZ    = 2;
    localparam int PF_PTR_IN_SZ = 4;
    localparam int PF_AF_LVL    = 3;

    typedef logic [PF_UWIDTH-1:0]    pf_unit_t;
    typedef logic [PF_PTR_IN_SZ-1:0] pf_len_t;

endpackage

// File: rtl/packet_fifo_mem.sv
// Packet storage: DEPTH entries of WIDTH units plus a per-entry length.
// Synchronous write, combinational (fall-through) read.
module packet_fifo_mem
    import packet_fifo_pkg::*;
#(
    parameter int DEPTH     = PF_DEPTH,
    parameter int WIDTH     = PF_WIDTH,
    parameter int UWIDTH    = PF_UWIDTH,
    parameter int PTR_SZ    = PF_PTR_SZ,
    parameter int PTR_IN_SZ = PF_PTR_IN_SZ
) (
    input  logic                 clk,
    input  logic                 unit_we,
    input  logic [PTR_SZ-1:0]    waddr,
    input  logic [PTR_IN_SZ-1:0] widx,
    input  logic [UWIDTH-1:0]    wdata,
    input  logic                 len_we,
    input  logic [PTR_IN_SZ-1:0] wlen,
    input  logic [PTR_SZ-1:0]    raddr,
    input  logic [PTR_IN_SZ-1:0] ridx,
    output logic [UWIDTH-1:0]    rdata,
    output logic [PTR_IN_SZ-1:0] rlen
);

    logic [UWIDTH-1:0]    units [DEPTH][WIDTH];
    logic [PTR_IN_SZ-1:0] lens  [DEPTH];

    always_ff @(posedge clk) begin
        if (unit_we) begin
            units[waddr][widx] <= wdata;
        end
        if (len_we) begin
            lens[waddr] <= wlen;
        end
    end

    always_comb begin
        rdata = units[raddr][ridx];
        rlen  = lens[raddr];
    end

endmodule

// File: rtl/packet_fifo.sv
// Packet FIFO: units are gathered into an entry and become readable only
// once the packet commits on wlast; oversize or dropped packets are discarded.
module packet_fifo
    import packet_fifo_pkg::*;
#(
    parameter int DEPTH     = PF_DEPTH,
    parameter int WIDTH     = PF_WIDTH,
    parameter int UWIDTH    = PF_UWIDTH,
    parameter int PTR_SZ    = PF_PTR_SZ,
    parameter int PTR_IN_SZ = PF_PTR_IN_SZ,
    parameter int AF_LVL    = PF_AF_LVL
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wvalid,
    input  logic [UWIDTH-1:0]    wdata,
    input  logic                 wlast,
    input  logic                 wdrop,
    output logic                 wready,
    input  logic                 rready,
    output logic                 rvalid,
    output logic [UWIDTH-1:0]    rdata,
    output logic                 rlast,
    output logic [PTR_IN_SZ-1:0] rlen,
    output logic                 wfull,
    output logic                 rempty,
    output logic                 almost_full,
    output logic [PTR_SZ:0]      count,
    output logic                 werr
);

    localparam logic [PTR_SZ:0]      DEPTH_C = (PTR_SZ+1)'(DEPTH);
    localparam logic [PTR_SZ:0]      AF_C    = (PTR_SZ+1)'(AF_LVL);
    localparam logic [PTR_SZ:0]      CNT_ONE = (PTR_SZ+1)'(1);
    localparam logic [PTR_SZ-1:0]    PTR_ONE = (PTR_SZ)'(1);
    localparam logic [PTR_IN_SZ-1:0] IDX_ONE = (PTR_IN_SZ)'(1);
    localparam logic [PTR_IN_SZ-1:0] WIDTH_C = (PTR_IN_SZ)'(WIDTH);

    logic [PTR_SZ-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_IN_SZ-1:0] widx_q, widx_d, ridx_q, ridx_d;
    logic [PTR_SZ:0]      count_q, count_d;
    logic                 bad_q, bad_d;
    logic                 werr_q, werr_d;

    logic wr_acc, ovf, unit_we, commit, rd_acc, rd_done;

    always_comb begin
        wfull       = (count_q == DEPTH_C);
        wready      = !wfull;
        rempty      = (count_q == '0);
        rvalid      = !rempty;
        almost_full = (count_q >= AF_C);
        count       = count_q;
        werr        = werr_q;
        rlast       = rvalid && (ridx_q == rlen - IDX_ONE);

        wr_acc  = wvalid && wready && !wdrop;
        ovf     = (widx_q == WIDTH_C);
        unit_we = wr_acc && !ovf;
        commit  = wr_acc && wlast && !ovf && !bad_q;
        rd_acc  = rvalid && rready;
        rd_done = rd_acc && rlast;

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        widx_d  = widx_q;
        ridx_d  = ridx_q;
        bad_d   = bad_q;
        werr_d  = 1'b0;
        count_d = count_q;

        // An overflowing unit parks widx at WIDTH; the packet then dies at its wlast.
        if (wdrop) begin
            widx_d = '0;
            bad_d  = 1'b0;
            werr_d = 1'b1;
        end else if (wr_acc) begin
            if (wlast) begin
                widx_d = '0;
                bad_d  = 1'b0;
                if (commit) begin
                    wptr_d = wptr_q + PTR_ONE;
                end else begin
                    werr_d = 1'b1;
                end
            end else if (ovf) begin
                bad_d = 1'b1;
            end else begin
                widx_d = widx_q + IDX_ONE;
            end
        end

        if (rd_acc) begin
            if (rlast) begin
                rptr_d = rptr_q + PTR_ONE;
                ridx_d = '0;
            end else begin
                ridx_d = ridx_q + IDX_ONE;
            end
        end

        case ({commit, rd_done})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            widx_q  <= '0;
            ridx_q  <= '0;
            count_q <= '0;
            bad_q   <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            widx_q  <= widx_d;
            ridx_q  <= ridx_d;
            count_q <= count_d;
            bad_q   <= bad_d;
            werr_q  <= werr_d;
        end
    end

    packet_fifo_mem #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .UWIDTH    (UWIDTH),
        .PTR_SZ    (PTR_SZ),
        .PTR_IN_SZ (PTR_IN_SZ)
    ) u_mem (
        .clk     (clk),
        .unit_we (unit_we),
        .waddr   (wptr_q),
        .widx    (widx_q),
        .wdata   (wdata),
        .len_we  (commit),
        .wlen    (widx_q + IDX_ONE),
        .raddr   (rptr_q),
        .ridx    (ridx_q),
        .rdata   (rdata),
        .rlen    (rlen)
    );

endmodule
